// File: rtl/axi_burst_master.sv
// -----------------------------------------------------------------------------
// axi_burst_master
//
// AXI4 burst master with independent write and read request ports. Each
// request is accepted with a full burst buffer. The request is checked for
// legality and then driven onto AXI4. The master reports the AXI response and
// any protocol error back to the user.
//
// Optional feature: define AXI_MASTER_TIMEOUT_EN to add a per-FSM watchdog.
// The watchdog aborts a transaction after timeout_cycles cycles without a
// handshake. When the macro is not defined, the FSMs wait indefinitely.
//
// Ports
//   clk, rst                     clock; synchronous active-high reset
//   aw* / w* / b*                AXI4 write address, data and response channels
//   ar* / r*                     AXI4 read address and data channels
//   start_wr, wr_addr, wr_len,   write request: strobe, address, beats-1,
//   wr_burst, wr_data, wr_strb   burst type, beat buffer, per-beat strobes
//   wr_busy, wr_done, wr_resp,   write status: busy, one-cycle done pulse,
//   wr_err                       BRESP, error (illegal request/bad BID/timeout)
//   start_rd, rd_addr, rd_len,   read request, same encoding as the write side
//   rd_burst
//   rd_data, rd_busy, rd_done,   registered read buffer and read status;
//   rd_resp, rd_err              rd_resp is the worst RRESP of the burst
// -----------------------------------------------------------------------------
module axi_burst_master #(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int id_width       = 4,
    parameter int max_beats      = 16,
    parameter int wr_id          = 1,
    parameter int rd_id          = 2,
    parameter int timeout_cycles = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst,
    output logic [id_width-1:0]                   awid,
    output logic [addr_width-1:0]                 awaddr,
    output logic [7:0]                            awlen,
    output logic [2:0]                            awsize,
    output logic [1:0]                            awburst,
    output logic                                  awvalid,
    input  logic                                  awready,
    output logic [data_width-1:0]                 wdata,
    output logic [data_width/8-1:0]               wstrb,
    output logic                                  wlast,
    output logic                                  wvalid,
    input  logic                                  wready,
    input  logic [id_width-1:0]                   bid,
    input  logic [1:0]                            bresp,
    input  logic                                  bvalid,
    output logic                                  bready,
    output logic [id_width-1:0]                   arid,
    output logic [addr_width-1:0]                 araddr,
    output logic [7:0]                            arlen,
    output logic [2:0]                            arsize,
    output logic [1:0]                            arburst,
    output logic                                  arvalid,
    input  logic                                  arready,
    input  logic [id_width-1:0]                   rid,
    input  logic [data_width-1:0]                 rdata,
    input  logic [1:0]                            rresp,
    input  logic                                  rlast,
    input  logic                                  rvalid,
    output logic                                  rready,
    input  logic                                  start_wr,
    input  logic [addr_width-1:0]                 wr_addr,
    input  logic [7:0]                            wr_len,
    input  logic [1:0]                            wr_burst,
    input  logic [max_beats*data_width-1:0]       wr_data,
    input  logic [max_beats*data_width/8-1:0]     wr_strb,
    output logic                                  wr_busy,
    output logic                                  wr_done,
    output logic [1:0]                            wr_resp,
    output logic                                  wr_err,
    input  logic                                  start_rd,
    input  logic [addr_width-1:0]                 rd_addr,
    input  logic [7:0]                            rd_len,
    input  logic [1:0]                            rd_burst,
    output logic [max_beats*data_width-1:0]       rd_data,
    output logic                                  rd_busy,
    output logic                                  rd_done,
    output logic [1:0]                            rd_resp,
    output logic                                  rd_err
);

    localparam int                  STRB_W  = data_width / 8;
    localparam logic [2:0]          SIZE    = 3'($clog2(STRB_W));
    localparam logic [id_width-1:0] WR_ID   = id_width'(wr_id);
    localparam logic [id_width-1:0] RD_ID   = id_width'(rd_id);
    localparam logic [1:0]          B_FIXED = 2'b00;
    localparam logic [1:0]          B_INCR  = 2'b01;
    localparam logic [1:0]          B_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP, W_DONE} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rd_state_t;

    // The length check comes first. After that, each burst type has its own rule.
    function automatic logic is_legal(input logic [11:0] addr_lo, input logic [7:0] len,
                                      input logic [1:0] burst);
        logic [31:0] bytes;
        logic [31:0] span;
        logic        ok;
        bytes = 32'(STRB_W);
        span  = 32'(addr_lo) + (32'(len) + 32'd1) * bytes;
        ok    = 1'b1;
        if (32'(len) >= 32'(max_beats)) begin
            ok = 1'b0;
        end else begin
            case (burst)
                B_FIXED: ok = (len <= 8'd15);
                B_INCR:  ok = (span <= 32'd4096);
                B_WRAP:  ok = (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) &&
                              ((32'(addr_lo) & (bytes - 32'd1)) == 32'd0);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    wr_state_t                         w_state, w_next;
    rd_state_t                         r_state, r_next;
    logic                              aw_sent, w_sent;
    logic [7:0]                        w_beat;
    logic [8:0]                        r_beat;
    logic [max_beats*data_width-1:0]   w_buf;
    logic [max_beats*STRB_W-1:0]       w_sbuf;
    logic                              wr_legal, rd_legal, wr_accept, rd_accept;
    logic                              aw_hs, w_hs, w_last_hs, b_hs, ar_hs, r_hs;
    logic                              w_tmo, r_tmo;

    assign wr_legal  = is_legal(wr_addr[11:0], wr_len, wr_burst);
    assign rd_legal  = is_legal(rd_addr[11:0], rd_len, rd_burst);
    assign wr_accept = (w_state == W_IDLE) && start_wr;
    assign rd_accept = (r_state == R_IDLE) && start_rd;

    // Handshakes are decoded from registered state. This keeps them free of
    // any combinational path through the FSM output logic.
    assign aw_hs     = (w_state == W_ISSUE) && !aw_sent && awready;
    assign w_hs      = (w_state == W_ISSUE) && !w_sent && wready;
    assign w_last_hs = w_hs && (w_beat == awlen);
    assign b_hs      = (w_state == W_RESP) && bvalid;
    assign ar_hs     = (r_state == R_ADDR) && arready;
    assign r_hs      = (r_state == R_DATA) && rvalid;

`ifdef AXI_MASTER_TIMEOUT_EN
    logic [31:0] w_tmo_cnt, r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_state == W_IDLE || w_state == W_DONE || aw_hs || w_hs || b_hs)
            w_tmo_cnt <= '0;
        else
            w_tmo_cnt <= w_tmo_cnt + 32'd1;
        if (rst || r_state == R_IDLE || r_state == R_DONE || ar_hs || r_hs)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end

    // The count is 0 in the first cycle after a handshake. Firing at
    // timeout_cycles-2 puts the done pulse exactly timeout_cycles cycles
    // after that handshake.
    assign w_tmo = (w_state == W_ISSUE || w_state == W_RESP) && !(aw_hs || w_hs || b_hs) &&
                   (w_tmo_cnt == 32'(timeout_cycles - 2));
    assign r_tmo = (r_state == R_ADDR || r_state == R_DATA) && !(ar_hs || r_hs) &&
                   (r_tmo_cnt == 32'(timeout_cycles - 2));
`else
    assign w_tmo = 1'b0;
    assign r_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // NOTE: every output and next-state variable gets a default before the
    // case statement. Otherwise a path that leaves one unassigned infers a latch.
    always_comb begin
        w_next  = w_state;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        bready  = 1'b0;
        wr_done = 1'b0;
        wr_busy = (w_state != W_IDLE);
        case (w_state)
            W_IDLE:  if (start_wr) w_next = wr_legal ? W_ISSUE : W_DONE;
            W_ISSUE: begin
                awvalid = !aw_sent;
                wvalid  = !w_sent;
                if (wvalid) begin
                    wdata = w_buf[int'(w_beat)*data_width +: data_width];
                    wstrb = w_sbuf[int'(w_beat)*STRB_W +: STRB_W];
                    wlast = (w_beat == awlen);
                end
                if ((aw_sent || aw_hs) && (w_sent || w_last_hs)) w_next = W_RESP;
                else if (w_tmo)                                   w_next = W_DONE;
            end
            W_RESP: begin
                bready = 1'b1;
                if (b_hs || w_tmo) w_next = W_DONE;
            end
            W_DONE: begin
                wr_done = 1'b1;
                w_next  = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next  = r_state;
        arvalid = 1'b0;
        rready  = 1'b0;
        rd_done = 1'b0;
        rd_busy = (r_state != R_IDLE);
        case (r_state)
            R_IDLE: if (start_rd) r_next = rd_legal ? R_ADDR : R_DONE;
            R_ADDR: begin
                arvalid = 1'b1;
                if (ar_hs)      r_next = R_DATA;
                else if (r_tmo) r_next = R_DONE;
            end
            R_DATA: begin
                rready = 1'b1;
                if ((r_hs && rlast) || r_tmo) r_next = R_DONE;
            end
            R_DONE: begin
                rd_done = 1'b1;
                r_next  = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // NOTE: the write beat buffer is not reset. It is always loaded on
    // acceptance before it is read, and wdata is gated to 0 outside valid.
    // rd_data is a visible output with a defined reset value, so it is reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            w_buf  <= wr_data;
            w_sbuf <= wr_strb;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples the pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            {awid, awaddr, awlen, awsize, awburst} <= '0;
            {aw_sent, w_sent, w_beat}              <= '0;
            {wr_resp, wr_err}                      <= '0;
        end else begin
            if (wr_accept) begin
                awid    <= WR_ID;
                awaddr  <= wr_addr;
                awlen   <= wr_len;
                awsize  <= SIZE;
                awburst <= wr_burst;
                aw_sent <= 1'b0;
                w_sent  <= 1'b0;
                w_beat  <= '0;
                wr_resp <= 2'b00;
                wr_err  <= !wr_legal;
            end
            if (aw_hs) aw_sent <= 1'b1;
            if (w_last_hs)  w_sent <= 1'b1;
            else if (w_hs)  w_beat <= w_beat + 8'd1;
            if (b_hs) begin
                wr_resp <= bresp;
                if (bid != WR_ID) wr_err <= 1'b1;
            end
            if (w_tmo) wr_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {arid, araddr, arlen, arsize, arburst} <= '0;
            r_beat                                 <= '0;
            {rd_resp, rd_err}                      <= '0;
            rd_data                                <= '0;
        end else begin
            if (rd_accept) begin
                arid    <= RD_ID;
                araddr  <= rd_addr;
                arlen   <= rd_len;
                arsize  <= SIZE;
                arburst <= rd_burst;
                r_beat  <= '0;
                rd_resp <= 2'b00;
                rd_err  <= !rd_legal;
                if (rd_legal) rd_data <= '0;
            end
            if (r_hs) begin
                // Beats past the buffer depth are consumed and dropped. The
                // counter saturates so that a runaway slave cannot wrap it.
                if (r_beat < 9'(max_beats))
                    rd_data[int'(r_beat)*data_width +: data_width] <= rdata;
                if (r_beat != 9'h1FF) r_beat <= r_beat + 9'd1;
                if (rresp > rd_resp) rd_resp <= rresp;
                if (rid != RD_ID) rd_err <= 1'b1;
                if (rlast != (r_beat == {1'b0, arlen})) rd_err <= 1'b1;
            end
            if (r_tmo) rd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// -----------------------------------------------------------------------------
// tb_axi_burst_master
//
// Directed self-checking bench for axi_burst_master with default widths
// (32-bit address and data, 4-bit IDs, 16-beat buffers). The slave side is
// driven step by step from a single initial block. Inputs change on the
// falling edge, and outputs are sampled there too.
// With AXI_MASTER_TIMEOUT_EN defined, an extra step checks the 16-cycle
// write watchdog.
// -----------------------------------------------------------------------------
module tb_axi_burst_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int MB = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [IW-1:0]      awid, arid, bid, rid;
    logic [AW-1:0]      awaddr, araddr, wr_addr, rd_addr;
    logic [7:0]         awlen, arlen, wr_len, rd_len;
    logic [2:0]         awsize, arsize;
    logic [1:0]         awburst, arburst, wr_burst, rd_burst;
    logic               awvalid, awready, wvalid, wready, wlast;
    logic [DW-1:0]      wdata, rdata;
    logic [DW/8-1:0]    wstrb;
    logic [1:0]         bresp, rresp, wr_resp, rd_resp;
    logic               bvalid, bready, arvalid, arready, rlast, rvalid, rready;
    logic               start_wr, start_rd, wr_busy, wr_done, wr_err;
    logic               rd_busy, rd_done, rd_err;
    logic [MB*DW-1:0]   wr_data, rd_data;
    logic [MB*DW/8-1:0] wr_strb;

    int                 n_tests = 0;
    int                 n_fail  = 0;
    logic [31:0]        exp_d [MB];
    logic [3:0]         exp_s [MB];

    axi_burst_master #(
        .addr_width(AW), .data_width(DW), .id_width(IW), .max_beats(MB),
        .wr_id(1), .rd_id(2), .timeout_cycles(16)
    ) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .start_wr(start_wr), .wr_addr(wr_addr), .wr_len(wr_len), .wr_burst(wr_burst),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_busy(wr_busy), .wr_done(wr_done),
        .wr_resp(wr_resp), .wr_err(wr_err),
        .start_rd(start_rd), .rd_addr(rd_addr), .rd_len(rd_len), .rd_burst(rd_burst),
        .rd_data(rd_data), .rd_busy(rd_busy), .rd_done(rd_done), .rd_resp(rd_resp),
        .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rd_beat(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    task automatic set_wr_buf(input logic [7:0] seed);
        for (int i = 0; i < MB; i++) begin
            exp_d[i] = {8'hD0, seed, 8'h00, 8'(i)};
            exp_s[i] = 4'(i + 1);
            wr_data[i*DW +: DW] = exp_d[i];
            wr_strb[i*4 +: 4]   = exp_s[i];
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_valids"}, {awvalid, wvalid, wlast, bready, arvalid, rready}, 0);
        check({p, "_status"}, {wr_busy, rd_busy, wr_done, rd_done, wr_err, rd_err}, 0);
        check({p, "_resp"}, {wr_resp, rd_resp}, 0);
        check({p, "_addr"}, {awaddr, araddr}, 0);
        check({p, "_len_id"}, {awlen, arlen, awid, arid}, 0);
        check({p, "_size_burst"}, {awsize, awburst, arsize, arburst}, 0);
        check({p, "_wdata_wstrb"}, {wdata, wstrb}, 0);
        check({p, "_rd_data"}, rd_data == '0, 1);
    endtask

    // Slave accepts AW/W at once, then answers B with the given response/ID.
    // Returns in the cycle after the B handshake.
    task automatic finish_write(input logic [1:0] resp, input logic [IW-1:0] id);
        awready = 1'b1;
        wready  = 1'b1;
        for (int k = 0; k < 50 && !bready; k++) tick();
        awready = 1'b0;
        wready  = 1'b0;
        check("fw_bready", bready, 1);
        bvalid = 1'b1; bid = id; bresp = resp;
        tick();
        bvalid = 1'b0;
    endtask

    task automatic illegal_write(input string p, input logic [31:0] a, input logic [7:0] l,
                                 input logic [1:0] b);
        wr_addr = a; wr_len = l; wr_burst = b; start_wr = 1'b1;
        tick();
        start_wr = 1'b0;
        check({p, "_no_valid"}, {awvalid, wvalid}, 0);
        check({p, "_done_err"}, {wr_done, wr_err}, 2'b11);
        check({p, "_resp"}, wr_resp, 0);
        tick();
        check({p, "_idle"}, wr_busy, 0);
    endtask

    // Issues a read, accepts AR immediately, then returns n beats with data
    // base+i. rlast is set on beat last_at, and RRESP=10 on beat bad_beat.
    // Returns in the cycle after the final beat.
    task automatic do_read(input string p, input logic [31:0] a, input logic [7:0] l,
                           input logic [1:0] b, input int n, input int last_at,
                           input logic [IW-1:0] rid_v, input logic [31:0] base, input int bad_beat);
        rd_addr = a; rd_len = l; rd_burst = b; start_rd = 1'b1;
        tick();
        start_rd = 1'b0;
        check({p, "_arvalid"}, arvalid, 1);
        check({p, "_ar_fields"}, {araddr, arlen, arburst, arsize, arid}, {a, l, b, 3'd2, 4'd2});
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check({p, "_rready"}, {rready, arvalid}, 2'b10);
        for (int i = 0; i < n; i++) begin
            rvalid = 1'b1;
            rid    = rid_v;
            rdata  = base + 32'(i);
            rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
            rlast  = (i == last_at);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    initial begin
        int beat, w_pre, done_at;
        logic aw_seen;

        rst = 1'b1;
        {awready, wready, bvalid, arready, rvalid, rlast, start_wr, start_rd} = '0;
        {bid, rid, bresp, rresp, rdata} = '0;
        {wr_addr, rd_addr, wr_len, rd_len, wr_burst, rd_burst} = '0;
        wr_data = '0;
        wr_strb = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset("rst0");

        // INCR write, 4 beats, slave always ready.
        set_wr_buf(8'h01);
        wr_addr = 32'h100; wr_len = 8'd3; wr_burst = 2'b01; start_wr = 1'b1;
        awready = 1'b1; wready = 1'b1;
        tick();
        start_wr = 1'b0;
        check("w1_busy", wr_busy, 1);
        check("w1_awvalid", awvalid, 1);
        check("w1_aw_fields", {awaddr, awlen, awsize, awburst, awid}, {32'h100, 8'd3, 3'd2, 2'b01, 4'd1});
        for (int i = 0; i < 4; i++) begin
            check("w1_wvalid", wvalid, 1);
            check("w1_wdata", wdata, exp_d[i]);
            check("w1_wstrb", wstrb, exp_s[i]);
            check("w1_wlast", wlast, i == 3);
            tick();
        end
        check("w1_bready", {bready, awvalid, wvalid}, 3'b100);
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        check("w1_done", {wr_done, wr_resp, wr_err}, 4'b1000);
        tick();
        check("w1_idle", {wr_done, wr_busy}, 0);

        // AW held off for 5 cycles and wready random: W runs ahead of AW.
        set_wr_buf(8'h02);
        wr_addr = 32'h200; wr_len = 8'd5; wr_burst = 2'b01; start_wr = 1'b1;
        tick();
        start_wr = 1'b0;
        beat = 0; w_pre = 0; aw_seen = 1'b0;
        for (int k = 0; k < 200 && !bready; k++) begin
            awready = (k >= 5);
            wready  = (k < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            if (awvalid && awready) begin
                aw_seen = 1'b1;
                check("w2_awaddr", awaddr, 32'h200);
            end
            if (wvalid && wready && beat < MB) begin
                check("w2_wdata", wdata, exp_d[beat]);
                check("w2_wstrb", wstrb, exp_s[beat]);
                check("w2_wlast", wlast, beat == 5);
                if (!aw_seen) w_pre++;
                beat++;
            end
            tick();
        end
        awready = 1'b0; wready = 1'b0;
        check("w2_bready", bready, 1);
        check("w2_beats", beat, 6);
        check("w2_aw_seen", aw_seen, 1);
        check("w2_w_before_aw", w_pre >= 2, 1);
        bvalid = 1'b1; bid = 4'd1; bresp = 2'b10;
        tick();
        bvalid = 1'b0;
        check("w2_done", {wr_done, wr_resp, wr_err}, 4'b1100);
        tick();

        // Wrong BID sets wr_err while the response is still reported.
        set_wr_buf(8'h03);
        wr_addr = 32'h300; wr_len = 8'd0; wr_burst = 2'b00; start_wr = 1'b1;
        tick();
        start_wr = 1'b0;
        finish_write(2'b01, 4'd5);
        check("w3_bad_bid", {wr_done, wr_resp, wr_err}, 4'b1011);
        tick();

        // INCR ending exactly on the 4 KB boundary is legal.
        wr_addr = 32'hFF0; wr_len = 8'd3; wr_burst = 2'b01; start_wr = 1'b1;
        tick();
        start_wr = 1'b0;
        check("w4_edge_legal", {awvalid, wr_err}, 2'b10);
        finish_write(2'b00, 4'd1);
        check("w4_done", {wr_done, wr_err}, 2'b10);
        tick();

        illegal_write("ill_4k", 32'hFF8, 8'd3, 2'b01);
        illegal_write("ill_len", 32'h000, 8'(MB), 2'b01);

        // WRAP read, 8 beats, SLVERR on beat 2.
        do_read("r1", 32'h1018, 8'd7, 2'b10, 8, 7, 4'd2, 32'hA0, 2);
        check("r1_done", {rd_done, rd_resp, rd_err}, 4'b1100);
        for (int i = 0; i < 8; i++) check("r1_data", rd_beat(i), 32'hA0 + 32'(i));
        check("r1_data_tail", rd_beat(8), 0);
        tick();
        check("r1_idle", rd_busy, 0);

        // Early rlast on beat 1 of len 3. The buffer was cleared on acceptance.
        do_read("r2", 32'h40, 8'd3, 2'b01, 2, 1, 4'd2, 32'hB0, 99);
        check("r2_done", {rd_done, rd_resp, rd_err}, 4'b1001);
        check("r2_data0", rd_beat(0), 32'hB0);
        check("r2_data1", rd_beat(1), 32'hB1);
        check("r2_cleared", rd_beat(2), 0);
        tick();
        check("r2_idle", rd_busy, 0);

        // Wrong RID.
        do_read("r3", 32'h80, 8'd1, 2'b01, 2, 1, 4'd3, 32'hC0, 99);
        check("r3_done", {rd_done, rd_err}, 2'b11);
        check("r3_data1", rd_beat(1), 32'hC1);
        tick();

        // Beat len passes without rlast. The extra beat is still stored.
        do_read("r4", 32'h90, 8'd1, 2'b01, 3, 2, 4'd2, 32'hD0, 99);
        check("r4_done", {rd_done, rd_err}, 2'b11);
        check("r4_data2", rd_beat(2), 32'hD2);
        tick();

        // Illegal WRAP read: no AR, err, resp cleared, buffer untouched.
        rd_addr = 32'h0; rd_len = 8'd2; rd_burst = 2'b10; start_rd = 1'b1;
        tick();
        start_rd = 1'b0;
        check("ill_wrap_no_ar", arvalid, 0);
        check("ill_wrap_done", {rd_done, rd_err, rd_resp}, 4'b1100);
        check("ill_wrap_keep", rd_beat(0), 32'hD0);
        tick();

`ifdef AXI_MASTER_TIMEOUT_EN
        // Watchdog: B never arrives; done must follow 16 cycles after AW/W.
        wr_addr = 32'h500; wr_len = 8'd0; wr_burst = 2'b01; start_wr = 1'b1;
        tick();
        start_wr = 1'b0;
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        done_at = 0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            if (wr_done) done_at = k;
            else tick();
        end
        check("tmo_delay", done_at, 16);
        check("tmo_err", {wr_err, bready}, 2'b10);
        tick();
`else
        done_at = 0;
`endif

        // Reset in the middle of a read burst.
        rd_addr = 32'h0; rd_len = 8'd3; rd_burst = 2'b01; start_rd = 1'b1;
        tick();
        start_rd = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd2; rdata = 32'hEE; rlast = 1'b0;
        tick();
        check("mid_rready", rready, 1);
        rst = 1'b1;
        tick();
        check_reset("rst1");
        rst = 1'b0;
        rvalid = 1'b0;
        tick();
        check("rst1_no_done", {rd_done, rd_busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
